// File: rtl/fifo_wptr_full_if.sv
// fifo_wptr_full_if: write-side bundle between the producer, the FIFO RAM write
// port, the read-domain pointer crossing and the write pointer/full generator.
//   wr_en        producer write request
//   rd_gray_ptr  read pointer in Gray code (asynchronous to the write clock)
//   wr_accept    RAM write strobe (combinational)
//   wr_addr      RAM write address
//   wr_gray_ptr  registered Gray write pointer, exported to the read domain
//   full         registered FIFO-full flag
//   almost_full  registered occupancy threshold flag
//   wr_level     registered occupancy estimate
// Modports: master = producer/environment side, slave = pointer generator.
interface fifo_wptr_full_if #(
    parameter int unsigned ASIZE = 4
);
    logic             wr_en;
    logic [ASIZE:0]   rd_gray_ptr;
    logic             wr_accept;
    logic [ASIZE-1:0] wr_addr;
    logic [ASIZE:0]   wr_gray_ptr;
    logic             full;
    logic             almost_full;
    logic [ASIZE:0]   wr_level;

    modport master (
        output wr_en, rd_gray_ptr,
        input  wr_accept, wr_addr, wr_gray_ptr, full, almost_full, wr_level
    );

    modport slave (
        input  wr_en, rd_gray_ptr,
        output wr_accept, wr_addr, wr_gray_ptr, full, almost_full, wr_level
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer and full-flag generator for an async FIFO.
// Holds the binary write pointer, exports it in Gray code, synchronises the
// read Gray pointer through two flops and registers the full flag.
// Ports:
//   clk  write-domain clock (rising edge)
//   rst  synchronous active-high reset
//   bus  fifo_wptr_full_if.slave (wr_en, rd_gray_ptr in; wr_accept, wr_addr,
//        wr_gray_ptr, full, almost_full, wr_level out)
// Optional feature: define FIFO_WPTR_ALMOST_FULL_EN to generate wr_level and
// almost_full from the synchronised read pointer; otherwise both are tied to 0.
module fifo_wptr_full #(
    parameter int unsigned ASIZE    = 4,
    parameter int unsigned AF_LEVEL = 14
) (
    input  logic             clk,
    input  logic             rst,
    fifo_wptr_full_if.slave  bus
);
    localparam int unsigned PW = ASIZE + 1;

    // Reject illegal configurations at elaboration.
    if (ASIZE < 2 || AF_LEVEL < 1 || AF_LEVEL > (1 << ASIZE)) begin : g_bad_param
        $error("fifo_wptr_full: illegal ASIZE/AF_LEVEL");
    end

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rq1;
    logic [PW-1:0] rq2;
    logic [PW-1:0] full_ptr;
    logic          full_q;
    logic          accept;

    // Next pointer values; full when the write Gray pointer equals the read
    // Gray pointer with its two MSBs inverted (one full lap ahead).
    always_comb begin
        accept     = bus.wr_en & ~full_q;
        wbin_next  = wbin + PW'(accept);
        wgray_next = wbin_next ^ (wbin_next >> 1);
        full_ptr   = {~rq2[ASIZE -: 2], rq2[ASIZE-2:0]};
    end

    // Pointer, synchroniser and full-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin   <= '0;
            wgray  <= '0;
            rq1    <= '0;
            rq2    <= '0;
            full_q <= 1'b0;
        end else begin
            wbin   <= wbin_next;
            wgray  <= wgray_next;
            rq1    <= bus.rd_gray_ptr;
            rq2    <= rq1;
            full_q <= (wgray_next == full_ptr);
        end
    end

    assign bus.wr_accept   = accept;
    assign bus.wr_addr     = wbin[ASIZE-1:0];
    assign bus.wr_gray_ptr = wgray;
    assign bus.full        = full_q;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] level_next;
    logic [PW-1:0] level_q;
    logic          af_q;

    // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i < int'(PW); i++) begin
            rbin_sync[i] = ^(rq2 >> i);
        end
        level_next = wbin_next - rbin_sync;
    end

    // Occupancy estimate; lags the read side exactly like full.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            af_q    <= 1'b0;
        end else begin
            level_q <= level_next;
            af_q    <= (level_next >= PW'(AF_LEVEL));
        end
    end

    assign bus.almost_full = af_q;
    assign bus.wr_level    = level_q;
`else
    assign bus.almost_full = 1'b0;
    assign bus.wr_level    = '0;
`endif

endmodule
